// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, error record, error sources and the
// channel-scheduler state encoding.
package dma_pkg;

  // Error source carried in an error record
  typedef enum logic [1:0] {
    DMA_NO_ERR        = 2'd0,
    DMA_UNALIGNED_ERR = 2'd1,
    DMA_BUS_ERR       = 2'd2,
    DMA_TIMEOUT_ERR   = 2'd3
  } dma_err_src_t;

  // Transfer descriptor handed from a channel to the streamers
  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] num_bytes;
  } s_dma_desc_t;

  // Error record reported by a streamer or by the scheduler watchdog
  typedef struct packed {
    logic         valid;
    dma_err_src_t src;
    logic [31:0]  addr;
  } s_dma_error_t;

  // Channel scheduler states
  typedef enum logic [1:0] {
    DMA_ST_IDLE = 2'd0,
    DMA_ST_RUN  = 2'd1,
    DMA_ST_DONE = 2'd2,
    DMA_ST_ERR  = 2'd3
  } dma_sched_st_t;

  // Width of a channel index; never narrower than one bit
  function automatic int dma_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_chan_sched_if.sv
// Channel / streamer bus of the DMA channel scheduler.
// slave  : the scheduler side.
// master : the side driving requests and streamer responses.
interface dma_chan_sched_if
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4
) ();

  localparam int IDX_W = dma_idx_w(NUM_CH);

  logic [NUM_CH-1:0]              ch_req_i;
  s_dma_desc_t [NUM_CH-1:0]       ch_desc_i;
  logic [NUM_CH-1:0]              ch_ack_o;
  logic [NUM_CH-1:0]              ch_done_o;
  logic [NUM_CH-1:0]              ch_err_o;
  s_dma_error_t                   err_info_o;
  logic                           err_clr_i;
  s_dma_desc_t                    stream_desc_o;
  logic                           rd_stream_valid_o;
  logic                           wr_stream_valid_o;
  logic                           rd_stream_done_i;
  logic                           wr_stream_done_i;
  s_dma_error_t                   rd_stream_err_i;
  s_dma_error_t                   wr_stream_err_i;
  logic                           busy_o;
  logic [IDX_W-1:0]               cur_ch_o;

  modport slave (
    input  ch_req_i, ch_desc_i, err_clr_i,
    input  rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i,
    output ch_ack_o, ch_done_o, ch_err_o, err_info_o, stream_desc_o,
    output rd_stream_valid_o, wr_stream_valid_o, busy_o, cur_ch_o
  );

  modport master (
    output ch_req_i, ch_desc_i, err_clr_i,
    output rd_stream_done_i, wr_stream_done_i, rd_stream_err_i, wr_stream_err_i,
    input  ch_ack_o, ch_done_o, ch_err_o, err_info_o, stream_desc_o,
    input  rd_stream_valid_o, wr_stream_valid_o, busy_o, cur_ch_o
  );

endinterface

// File: rtl/dma_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i+1 and
// wraps, so the channel granted last has the lowest priority next time.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = dma_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  // First requester found walking upward from the pointer wins
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        idx_o           = cand_idx;
        gnt_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// DMA channel scheduler: grants one channel at a time (round robin),
// latches its descriptor, starts the read and write streamers and
// reports completion or error back to the owning channel.
// Optional feature: define DMA_SCHED_WDT_EN to add a RUN-state watchdog
// that raises DMA_TIMEOUT_ERR after WDT_CYCLES cycles without completion.
module dma_chan_sched
  import dma_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int WDT_CYCLES = 65535
) (
  input logic             clk,
  input logic             rstn,
  dma_chan_sched_if.slave bus
);

  localparam int IDX_W = dma_idx_w(NUM_CH);

  dma_sched_st_t     state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  cur_ch_q, cur_ch_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  s_dma_desc_t       desc_q, desc_d;
  s_dma_error_t      err_q, err_d;
  logic              rd_seen_q, rd_seen_d;
  logic              wr_seen_q, wr_seen_d;
  logic              wdt_hit;

  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i   (bus.ch_req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

`ifdef DMA_SCHED_WDT_EN
  logic [31:0] wdt_q, wdt_d;

  // Watchdog counts RUN cycles; held at zero in IDLE so RUN always starts fresh
  always_comb begin
    wdt_d = wdt_q;
    if (state_q == DMA_ST_IDLE)     wdt_d = '0;
    else if (state_q == DMA_ST_RUN) wdt_d = wdt_q + 32'd1;
  end

  assign wdt_hit = (state_q == DMA_ST_RUN) && (wdt_q == 32'(WDT_CYCLES - 1));

  // Watchdog register
  always_ff @(posedge clk) begin
    if (!rstn) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`else
  assign wdt_hit = 1'b0;
`endif

  // Next-state logic: grant in IDLE, track streamer completion in RUN,
  // errors (streamer first, then watchdog) override a same-cycle done
  always_comb begin
    logic rd_fin;
    logic wr_fin;
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cur_ch_d  = cur_ch_q;
    ack_d     = '0;
    desc_d    = desc_q;
    err_d     = err_q;
    rd_seen_d = rd_seen_q;
    wr_seen_d = wr_seen_q;
    rd_fin    = rd_seen_q | bus.rd_stream_done_i;
    wr_fin    = wr_seen_q | bus.wr_stream_done_i;
    case (state_q)
      DMA_ST_IDLE: begin
        if (arb_valid) begin
          ack_d     = arb_gnt;
          rr_ptr_d  = arb_idx;
          cur_ch_d  = arb_idx;
          desc_d    = bus.ch_desc_i[arb_idx];
          rd_seen_d = 1'b0;
          wr_seen_d = 1'b0;
          // A zero-length transfer never starts the streamers
          state_d   = (bus.ch_desc_i[arb_idx].num_bytes == '0) ? DMA_ST_DONE : DMA_ST_RUN;
        end
      end
      DMA_ST_RUN: begin
        rd_seen_d = rd_fin;
        wr_seen_d = wr_fin;
        if (bus.rd_stream_err_i.valid || bus.wr_stream_err_i.valid) begin
          state_d = DMA_ST_ERR;
          err_d   = bus.rd_stream_err_i.valid ? bus.rd_stream_err_i : bus.wr_stream_err_i;
        end else if (wdt_hit) begin
          state_d = DMA_ST_ERR;
          err_d   = '{valid: 1'b1, src: DMA_TIMEOUT_ERR, addr: desc_q.src_addr};
        end else if (rd_fin && wr_fin) begin
          state_d = DMA_ST_DONE;
        end
      end
      DMA_ST_DONE: state_d = DMA_ST_IDLE;
      DMA_ST_ERR:  if (bus.err_clr_i) state_d = DMA_ST_IDLE;
      default:     state_d = DMA_ST_IDLE;
    endcase
  end

  // State and latch registers; reset leaves channel 0 first in line
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= DMA_ST_IDLE;
      rr_ptr_q  <= IDX_W'(NUM_CH - 1);
      cur_ch_q  <= '0;
      ack_q     <= '0;
      desc_q    <= '0;
      err_q     <= '0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      cur_ch_q  <= cur_ch_d;
      ack_q     <= ack_d;
      desc_q    <= desc_d;
      err_q     <= err_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
    end
  end

  assign bus.ch_ack_o          = ack_q;
  assign bus.busy_o            = (state_q != DMA_ST_IDLE);
  assign bus.cur_ch_o          = cur_ch_q;
  assign bus.stream_desc_o     = desc_q;
  assign bus.err_info_o        = err_q;
  assign bus.rd_stream_valid_o = (state_q == DMA_ST_RUN) && !rd_seen_q;
  assign bus.wr_stream_valid_o = (state_q == DMA_ST_RUN) && !wr_seen_q;

  // Per-channel done pulse (DONE lasts one cycle) and error level
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_out
    assign bus.ch_done_o[gi] = (state_q == DMA_ST_DONE) && (cur_ch_q == IDX_W'(gi));
    assign bus.ch_err_o[gi]  = (state_q == DMA_ST_ERR)  && (cur_ch_q == IDX_W'(gi));
  end

endmodule
